// File: rtl/pwm_dac_pkg.sv
// rtl/pwm_dac_pkg.sv - shared defaults and constants for the PWM DAC stage
package pwm_dac_pkg;

  localparam int CODE_WIDTH_DEF = 10;
  localparam int FIFO_DEPTH_DEF = 4;

  // Last counter value of a PWM period; the period boundary sits here
  function automatic int period_max(input int code_width);
    return (1 << code_width) - 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head output
module sync_fifo
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH = CODE_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // A write into a full FIFO is dropped even if a read happens in the same cycle
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy lives in count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// rtl/pwm_dac.sv - buffered PWM DAC emitting one period per duty code
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int CODE_WIDTH = CODE_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [CODE_WIDTH-1:0]         code,
  input  logic                          code_valid,
  output logic                          code_ready,
  output logic                          pwm,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam logic [CODE_WIDTH-1:0] CNT_MAX = CODE_WIDTH'(period_max(CODE_WIDTH));

  logic [CODE_WIDTH-1:0] cnt;
  logic [CODE_WIDTH-1:0] duty;
  logic [CODE_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  boundary;
  logic                  pop;
  logic                  push;

  // code_ready depends only on occupancy, never on a same-cycle pop
  assign code_ready = !fifo_full;
  assign push       = code_valid && !fifo_full;
  assign boundary   = enable && (cnt == CNT_MAX);
  assign pop        = boundary && !fifo_empty;
  assign underrun   = boundary && fifo_empty;

  sync_fifo #(
    .WIDTH (CODE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (push),
    .din   (code),
    .full  (fifo_full),
    .rd_en (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fill)
  );

  // Period counter: free-runs while enabled, parked at zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Duty register: loads the FIFO head at a boundary, otherwise repeats the last sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
    end else if (pop) begin
      duty <= fifo_dout;
    end
  end

  // Registered compare feeding the IOB flop directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= enable && (cnt < duty);
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// tb/tb_pwm_dac.sv - scoreboard bench for pwm_dac against a queue-based model
module tb_pwm_dac;

  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int PLEN  = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [CW-1:0] code;
  logic          code_valid;
  logic          code_ready;
  logic          pwm;
  logic          underrun;
  logic [2:0]    fill;

  pwm_dac #(.CODE_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pwm        (pwm),
    .underrun   (underrun),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pwm;
    logic underrun;
    int   fill;
    logic ready;
  } exp_t;

  exp_t exp_q[$];
  int   mq[$];
  int   m_duty;
  int   m_phase;
  logic m_pwm;
  int   checks;
  int   failures;
  logic acc;
  int   guard;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_duty  = 0;
    m_phase = 0;
    m_pwm   = 1'b0;
  endfunction

  // One clock of stimulus: publish the expected outputs for this cycle, then advance the model
  task automatic step(input logic en, input logic v, input logic [CW-1:0] c, output logic accepted);
    exp_t e;
    logic bnd;
    int   dold;
    enable     = en;
    code_valid = v;
    code       = c;
    bnd        = en && (m_phase == PLEN - 1);
    e.pwm      = m_pwm;
    e.fill     = mq.size();
    e.ready    = (mq.size() < DEPTH);
    e.underrun = bnd && (mq.size() == 0);
    exp_q.push_back(e);
    @(posedge clk);
    accepted = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      accepted = v && (mq.size() < DEPTH);
      dold     = m_duty;
      if (bnd && mq.size() > 0) m_duty = mq.pop_front();
      if (accepted) mq.push_back(int'(c));
      m_pwm   = en && (m_phase < dold);
      m_phase = en ? (m_phase + 1) % PLEN : 0;
    end
    #1;
  endtask

  task automatic run(input int n, input logic en);
    logic a;
    for (int i = 0; i < n; i++) step(en, 1'b0, '0, a);
  endtask

  // Monitor: compares DUT outputs against the scoreboard once per cycle, away from the edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("pwm", 32'(pwm), 32'(e.pwm));
        check("underrun", 32'(underrun), 32'(e.underrun));
        check("fill", 32'(fill), e.fill);
        check("code_ready", 32'(code_ready), 32'(e.ready));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s2_codes[4];
    int s3_codes[6];
    int idx;
    logic en_r;
    s2_codes = '{4, 8, 0, 15};
    s3_codes = '{3, 12, 1, 9, 14, 6};
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    code_valid = 1'b0;
    code = '0;
    model_reset();
    @(posedge clk);
    #1;
    // Handshakes while in reset must be ignored
    step(1'b1, 1'b1, 4'd5, acc);
    step(1'b1, 1'b1, 4'd6, acc);
    rst_n = 1'b1;

    // Idle generator: underrun every 16 cycles, pwm stays low
    run(64, 1'b1);

    // Four queued codes, then an underrun that repeats the last one
    foreach (s2_codes[i]) step(1'b1, 1'b1, CW'(s2_codes[i]), acc);
    run(5 * PLEN, 1'b1);

    // Continuous valid against a full FIFO
    idx = 0;
    guard = 0;
    while (idx < 6 && guard < 200) begin
      step(1'b1, 1'b1, CW'(s3_codes[idx]), acc);
      if (acc) idx++;
      guard++;
    end
    check("s3_all_pushed", idx, 6);
    run(7 * PLEN, 1'b1);

    // Push landing exactly on an empty-FIFO boundary
    guard = 0;
    while (!(m_phase == PLEN - 1 && mq.size() == 0) && guard < 100) begin
      step(1'b1, 1'b0, '0, acc);
      guard++;
    end
    check("s4_reach_boundary", 32'(guard < 100), 1);
    step(1'b1, 1'b1, 4'd7, acc);
    run(40, 1'b1);

    // Disable mid-period with duty 10, then resume
    step(1'b1, 1'b1, 4'd10, acc);
    guard = 0;
    while (!(m_duty == 10 && m_phase == 6) && guard < 100) begin
      step(1'b1, 1'b0, '0, acc);
      guard++;
    end
    check("s5_reach_cnt6", 32'(guard < 100), 1);
    step(1'b1, 1'b1, 4'd2, acc);
    run(6, 1'b0);
    run(2 * PLEN, 1'b1);

    // Asynchronous reset with entries queued
    step(1'b1, 1'b1, 4'd11, acc);
    step(1'b1, 1'b1, 4'd13, acc);
    step(1'b1, 1'b1, 4'd9, acc);
    guard = 0;
    while (m_phase != 5 && guard < 100) begin
      step(1'b1, 1'b0, '0, acc);
      guard++;
    end
    #4;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm), 0);
    check("async_rst_fill", 32'(fill), 0);
    check("async_rst_ready", 32'(code_ready), 1);
    check("async_rst_underrun", 32'(underrun), 0);
    model_reset();
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 4'd3, acc);
    rst_n = 1'b1;
    run(64, 1'b1);

    // Randomised traffic with occasional enable toggling
    en_r = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) en_r = !en_r;
      step(en_r, ($urandom_range(0, 2) == 0), CW'($urandom), acc);
    end
    run(2, 1'b1);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_dac.md
Name: pwm_dac

Overview:
- Audio PWM DAC stage that drives the top-level PWM IOB register from the CPU/audio side.
- Accepts CODE_WIDTH-bit duty codes over a valid/ready handshake and buffers them in a small FIFO.
- Emits one PWM period of 2^CODE_WIDTH cycles per code.
- Runs entirely on pwm_clk; its pwm output connects directly to the IOB flop input (pwm_out).

Parameters:
- CODE_WIDTH, 10, duty code width; PWM period = 2^CODE_WIDTH clk cycles.
- FIFO_DEPTH, 4, sample buffer entries; power of two, >= 2.

Ports:
- clk  input  1  PWM clock domain clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run PWM; when low, generator is idle and FIFO still accepts.
- code  input  CODE_WIDTH  duty code, unsigned.
- code_valid  input  1  code present.
- code_ready  output  1  FIFO can accept; high iff fill < FIFO_DEPTH.
- pwm  output  1  registered PWM bit to IOB.
- underrun  output  1  one-cycle pulse: period boundary reached with FIFO empty.
- fill  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: cnt=0, duty=0, pwm=0, underrun=0, FIFO empty (fill=0, code_ready=1). Handshakes are ignored while rst_n is low.
- Push occurs when code_valid && code_ready at a clk edge. There is no push when full, even with a simultaneous pop; code_ready is not a function of pop.
- Counter cnt (CODE_WIDTH bits):
  - Increments by 1 each cycle while enable=1.
  - Wraps 2^CODE_WIDTH-1 -> 0.
  - Held at 0 while enable=0.
- Compare: pwm <= enable && (cnt < duty). This gives one cycle of registered latency from cnt/duty to pwm.
  - duty=0: pwm constantly 0.
  - duty=2^W-1: pwm high for 2^W-1 of every 2^W cycles.
- Period boundary is the cycle where enable=1 and cnt==2^W-1:
  - FIFO non-empty: pop head into duty. The new duty is visible in the compare from cnt=0 and on pwm from the following cycle.
  - FIFO empty: duty is held (last sample repeats) and underrun=1 for exactly that cycle.
- Push and pop in the same cycle: fill is unchanged; both occur.
- Push into an empty FIFO in the boundary cycle: there is no bypass. The pop sees empty, underrun fires, and the code is used at the next boundary.
- enable falling mid-period:
  - Next cycle: cnt=0, pwm=0.
  - duty is retained and no pops occur.
  - On re-enable, the period restarts at cnt=0 with the retained duty.
- Reset mid-period: immediate return to reset values, and FIFO contents are discarded.
- FIFO pointers are log2(FIFO_DEPTH) bits, wrap naturally, and occupancy is tracked in fill.

Decomposition:
- Shared package pwm_dac_pkg: default CODE_WIDTH, FIFO_DEPTH, and the PERIOD_MAX = 2^CODE_WIDTH-1 constant function.
- Sub-module: sync_fifo (WIDTH, DEPTH; ports clk, rst_n, wr_en, din, full, rd_en, dout, empty, count).
  - Reusable for the CPU-side audio path.
  - Combinational dout of the head entry.
- pwm_dac holds the counter, the duty register, the compare/output register, and the underrun logic.

Test Plan (CODE_WIDTH=4, FIFO_DEPTH=4):
- Reset release, enable=1, no pushes: pwm=0 for 64 cycles; underrun pulses at cycles 15, 31, 47, 63 after release.
- Push codes 4, 8, 0, 15 before the first boundary: FIFO fills; periods show pwm high 4, 8, 0, 15 cycles respectively. The 5th boundary then underruns and 15 repeats.
- Keep code_valid=1 with 6 codes while the FIFO is full: code_ready drops after the 4th push and reasserts the cycle after each pop. fill never exceeds 4, and no code is lost or duplicated.
- Push in the exact boundary cycle with the FIFO empty: underrun=1 that cycle; the pushed code appears in the following period, not the current one.
- Deassert enable at cnt=6 with duty=10: pwm=0 the next cycle and cnt=0. Re-enable: pwm high 10 cycles from restart, and fill is unchanged while disabled.
- Assert rst_n=0 mid-period with 3 entries queued: pwm=0, fill=0, code_ready=1 immediately (asynchronously); after release, behaviour matches the first scenario.
